pipe_ctrl: RTL and testbench

- Control and hazard sequencer for the 5-stage MIPS pipeline datapath.
- Decodes the instruction held in ID and carries its control bits through the ID/EX, EX/MEM and MEM/WB control registers.
- Resolves branches in MEM and detects load-use and branch/jump hazards.
- Drives the stall, flush and forwarding selects the datapath needs to run back-to-back dependent code correctly.

---
 rtl/pipe_ctrl_if.sv | 45 ++++
 rtl/pipe_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Control/hazard bundle between the MIPS datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if #(
  parameter int unsigned ALUW = 3,
  parameter int unsigned RW   = 5
);
  // datapath -> control
  logic [5:0]      opD;
  logic [5:0]      functD;
  logic [RW-1:0]   rsD;
  logic [RW-1:0]   rtD;
  logic [RW-1:0]   rsE;
  logic [RW-1:0]   rtE;
  logic [RW-1:0]   writeregE;
  logic [RW-1:0]   writeregM;
  logic [RW-1:0]   writeregW;
  logic            zeroM;
  // control -> datapath
  logic            jump;
  logic            regdstE;
  logic            alusrcE;
  logic [ALUW-1:0] alucontrolE;
  logic            memwriteM;
  logic            pcsrcM;
  logic            regwriteW;
  logic            memtoregW;
  logic            stallF;
  logic            stallD;
  logic            flushD;
  logic            flushE;
  logic [1:0]      forwardAE;
  logic [1:0]      forwardBE;
  logic [15:0]     stallcnt;

  modport master (
    output opD, functD, rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW, zeroM,
    input  jump, regdstE, alusrcE, alucontrolE, memwriteM, pcsrcM, regwriteW, memtoregW,
           stallF, stallD, flushD, flushE, forwardAE, forwardBE, stallcnt
  );

  modport slave (
    input  opD, functD, rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW, zeroM,
    output jump, regdstE, alusrcE, alucontrolE, memwriteM, pcsrcM, regwriteW, memtoregW,
           stallF, stallD, flushD, flushE, forwardAE, forwardBE, stallcnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: decode, control pipeline and hazard unit for a 5-stage MIPS core.
// Optional feature macro FORWARDING_EN: when defined, EX operands are forwarded
// from MEM/WB and only load-use stalls; when undefined, every RAW hazard stalls.
module pipe_ctrl #(
  parameter int unsigned ALUW = 3,
  parameter int unsigned RW   = 5
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

`ifdef FORWARDING_EN
  localparam bit fwd_on = 1'b1;
`else
  localparam bit fwd_on = 1'b0;
`endif

  localparam logic [RW-1:0] reg_zero = '0;

  typedef struct packed {
    logic            regwrite;
    logic            memtoreg;
    logic            memwrite;
    logic            branch;
    logic            alusrc;
    logic            regdst;
    logic [ALUW-1:0] alucontrol;
  } ctl_t;

  ctl_t        ctl_d;
  ctl_t        ctl_e;
  logic        jump_d;
  logic        regwrite_m, memtoreg_m, memwrite_m, branch_m;
  logic        regwrite_w, memtoreg_w;
  logic [15:0] stall_cnt;

  logic        lw_hz, raw_rs, raw_rt, hz;
  logic        pcsrc, stall, flush_d, flush_e, jump_o;
  logic [1:0]  fa, fb;

  // Main decoder for the instruction held in ID; unknown encodings become NOPs.
  always_comb begin
    ctl_d  = '0;
    jump_d = 1'b0;
    case (bus.opD)
      6'b000000: begin
        ctl_d.regwrite = 1'b1;
        ctl_d.regdst   = 1'b1;
        case (bus.functD)
          6'b100000: ctl_d.alucontrol = ALUW'(3'b010);
          6'b100010: ctl_d.alucontrol = ALUW'(3'b110);
          6'b100100: ctl_d.alucontrol = ALUW'(3'b000);
          6'b100101: ctl_d.alucontrol = ALUW'(3'b001);
          6'b101010: ctl_d.alucontrol = ALUW'(3'b111);
          default:   ctl_d = '0;
        endcase
      end
      6'b100011: begin
        ctl_d.regwrite   = 1'b1;
        ctl_d.memtoreg   = 1'b1;
        ctl_d.alusrc     = 1'b1;
        ctl_d.alucontrol = ALUW'(3'b010);
      end
      6'b101011: begin
        ctl_d.memwrite   = 1'b1;
        ctl_d.alusrc     = 1'b1;
        ctl_d.alucontrol = ALUW'(3'b010);
      end
      6'b000100: begin
        ctl_d.branch     = 1'b1;
        ctl_d.alucontrol = ALUW'(3'b110);
      end
      6'b001000: begin
        ctl_d.regwrite   = 1'b1;
        ctl_d.alusrc     = 1'b1;
        ctl_d.alucontrol = ALUW'(3'b010);
      end
      6'b000010: jump_d = 1'b1;
      default: ;
    endcase
  end

  // Hazard detection and forwarding selects; register 0 never matches.
  always_comb begin
    lw_hz  = ctl_e.memtoreg & ctl_e.regwrite & (bus.writeregE != reg_zero) &
             ((bus.writeregE == bus.rsD) | (bus.writeregE == bus.rtD));
    raw_rs = (bus.rsD != reg_zero) &
             ((ctl_e.regwrite & (bus.rsD == bus.writeregE)) |
              (regwrite_m     & (bus.rsD == bus.writeregM)) |
              (regwrite_w     & (bus.rsD == bus.writeregW)));
    raw_rt = (bus.rtD != reg_zero) &
             ((ctl_e.regwrite & (bus.rtD == bus.writeregE)) |
              (regwrite_m     & (bus.rtD == bus.writeregM)) |
              (regwrite_w     & (bus.rtD == bus.writeregW)));
    hz     = fwd_on ? lw_hz : (raw_rs | raw_rt);

    fa = 2'b00;
    if (regwrite_m && (bus.writeregM != reg_zero) && (bus.writeregM == bus.rsE))
      fa = 2'b10;
    else if (regwrite_w && (bus.writeregW != reg_zero) && (bus.writeregW == bus.rsE))
      fa = 2'b01;

    fb = 2'b00;
    if (regwrite_m && (bus.writeregM != reg_zero) && (bus.writeregM == bus.rtE))
      fb = 2'b10;
    else if (regwrite_w && (bus.writeregW != reg_zero) && (bus.writeregW == bus.rtE))
      fb = 2'b01;
  end

  // Stall/flush arbitration: a taken branch overrides stalls and kills a jump in ID.
  always_comb begin
    pcsrc   = branch_m & bus.zeroM;
    stall   = hz & ~pcsrc;
    flush_e = hz | pcsrc;
    jump_o  = jump_d & ~pcsrc & ~stall;
    flush_d = pcsrc | jump_o;
  end

  // Control pipeline D->E->M->W and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_e      <= '0;
      regwrite_m <= 1'b0;
      memtoreg_m <= 1'b0;
      memwrite_m <= 1'b0;
      branch_m   <= 1'b0;
      regwrite_w <= 1'b0;
      memtoreg_w <= 1'b0;
      stall_cnt  <= 16'h0000;
    end else begin
      ctl_e      <= flush_e ? '0 : ctl_d;
      regwrite_m <= pcsrc ? 1'b0 : ctl_e.regwrite;
      memtoreg_m <= pcsrc ? 1'b0 : ctl_e.memtoreg;
      memwrite_m <= pcsrc ? 1'b0 : ctl_e.memwrite;
      branch_m   <= pcsrc ? 1'b0 : ctl_e.branch;
      regwrite_w <= regwrite_m;
      memtoreg_w <= memtoreg_m;
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.jump        = jump_o;
  assign bus.regdstE     = ctl_e.regdst;
  assign bus.alusrcE     = ctl_e.alusrc;
  assign bus.alucontrolE = ctl_e.alucontrol;
  assign bus.memwriteM   = memwrite_m;
  assign bus.pcsrcM      = pcsrc;
  assign bus.regwriteW   = regwrite_w;
  assign bus.memtoregW   = memtoreg_w;
  assign bus.stallF      = stall;
  assign bus.stallD      = stall;
  assign bus.flushD      = flush_d;
  assign bus.flushE      = flush_e;
  assign bus.forwardAE   = fwd_on ? fa : 2'b00;
  assign bus.forwardBE   = fwd_on ? fb : 2'b00;
  assign bus.stallcnt    = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: instruction-level pipeline model with per-stage
// control scoreboards, directed hazard sequences, random code and a mid-run reset.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.ALUW(3), .RW(5)) bus ();
  pipe_ctrl #(.ALUW(3), .RW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wr;
    logic       tk;
  } ins_t;

  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic       mw;
    logic       br;
    logic       as;
    logic       rd;
    logic [2:0] alu;
  } ctl_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  ins_t prog[$];
  ctl_t qe[$], qm[$], qw[$];
  ins_t s_d, s_e, s_m, s_w;
  int   pc;
  logic [15:0] cnt_m;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected control bits straight from the opcode/funct table.
  function automatic ctl_t dec(input ins_t i);
    ctl_t c = '0;
    case (i.op)
      6'h00: case (i.fn)
        6'h20: c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010};
        6'h22: c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110};
        6'h24: c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
        6'h25: c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001};
        6'h2a: c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111};
        default: c = '0;
      endcase
      6'h23: c = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010};
      6'h2b: c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010};
      6'h04: c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110};
      6'h08: c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010};
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ins_t r_ins(input logic [5:0] fn, input int rd, input int rs, input int rt);
    return '{6'h00, fn, 5'(rs), 5'(rt), 5'(rd), 1'b0};
  endfunction

  function automatic ins_t i_ins(input logic [5:0] op, input int rt, input int rs, input logic tk);
    return '{op, 6'h00, 5'(rs), 5'(rt), 5'(rt), tk};
  endfunction

  function automatic ins_t j_ins();
    return '{6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0};
  endfunction

  function automatic ins_t rnd_ins();
    int k  = int'($urandom_range(0, 9));
    int a  = int'($urandom_range(0, 3));
    int b  = int'($urandom_range(0, 3));
    int c  = int'($urandom_range(0, 3));
    logic t = 1'($urandom_range(0, 1));
    case (k)
      0: return r_ins(6'h20, a, b, c);
      1: return r_ins(6'h22, a, b, c);
      2: return r_ins(6'h24, a, b, c);
      3: return r_ins(6'h25, a, b, c);
      4: return r_ins(6'h2a, a, b, c);
      5: return i_ins(6'h23, a, b, 1'b0);
      6: return i_ins(6'h2b, a, b, 1'b0);
      7: return i_ins(6'h08, a, b, 1'b0);
      8: return i_ins(6'h04, a, b, t);
      default: return j_ins();
    endcase
  endfunction

  task automatic model_reset();
    s_d = '0; s_e = '0; s_m = '0; s_w = '0;
    qe.delete(); qm.delete(); qw.delete();
    qe.push_back('0); qm.push_back('0); qw.push_back('0);
    cnt_m = 16'h0000;
  endtask

  // One clock: drive the model's stage contents, check outputs, advance the model.
  task automatic step();
    ctl_t ce, cm, cw;
    logic zm, hz, pce, st, fe, fd, je;
    logic [1:0] fa, fb;
    ce = qe.pop_front();
    cm = qm.pop_front();
    cw = qw.pop_front();
    zm = cm.br ? s_m.tk : 1'($urandom_range(0, 1));
    bus.opD = s_d.op;   bus.functD = s_d.fn;
    bus.rsD = s_d.rs;   bus.rtD = s_d.rt;
    bus.rsE = s_e.rs;   bus.rtE = s_e.rt;
    bus.writeregE = s_e.wr;
    bus.writeregM = s_m.wr;
    bus.writeregW = s_w.wr;
    bus.zeroM = zm;

    pce = cm.br & zm;
`ifdef FORWARDING_EN
    hz = ce.m2r && ce.rw && s_e.wr != 0 && (s_e.wr == s_d.rs || s_e.wr == s_d.rt);
    fa = (cm.rw && s_m.wr != 0 && s_m.wr == s_e.rs) ? 2'b10 :
         (cw.rw && s_w.wr != 0 && s_w.wr == s_e.rs) ? 2'b01 : 2'b00;
    fb = (cm.rw && s_m.wr != 0 && s_m.wr == s_e.rt) ? 2'b10 :
         (cw.rw && s_w.wr != 0 && s_w.wr == s_e.rt) ? 2'b01 : 2'b00;
`else
    hz = (s_d.rs != 0 && ((ce.rw && s_e.wr == s_d.rs) || (cm.rw && s_m.wr == s_d.rs) ||
                          (cw.rw && s_w.wr == s_d.rs))) ||
         (s_d.rt != 0 && ((ce.rw && s_e.wr == s_d.rt) || (cm.rw && s_m.wr == s_d.rt) ||
                          (cw.rw && s_w.wr == s_d.rt)));
    fa = 2'b00;
    fb = 2'b00;
`endif
    st = hz && !pce;
    fe = hz || pce;
    je = (s_d.op == 6'h02) && !pce && !st;
    fd = pce || je;

    #3;
    check_val("regdstE",     32'(bus.regdstE),     32'(ce.rd));
    check_val("alusrcE",     32'(bus.alusrcE),     32'(ce.as));
    check_val("alucontrolE", 32'(bus.alucontrolE), 32'(ce.alu));
    check_val("memwriteM",   32'(bus.memwriteM),   32'(cm.mw));
    check_val("regwriteW",   32'(bus.regwriteW),   32'(cw.rw));
    check_val("memtoregW",   32'(bus.memtoregW),   32'(cw.m2r));
    check_val("pcsrcM",      32'(bus.pcsrcM),      32'(pce));
    check_val("stallF",      32'(bus.stallF),      32'(st));
    check_val("stallD",      32'(bus.stallD),      32'(st));
    check_val("flushD",      32'(bus.flushD),      32'(fd));
    check_val("flushE",      32'(bus.flushE),      32'(fe));
    check_val("jump",        32'(bus.jump),        32'(je));
    check_val("forwardAE",   32'(bus.forwardAE),   32'(fa));
    check_val("forwardBE",   32'(bus.forwardBE),   32'(fb));
    check_val("stallcnt",    32'(bus.stallcnt),    32'(cnt_m));

    @(posedge clk);
    #1;
    cyc++;
    if (st && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    qw.push_back(cm);
    qm.push_back(pce ? ctl_t'('0) : ce);
    qe.push_back(fe ? ctl_t'('0) : dec(s_d));
    s_w = s_m;
    s_m = pce ? ins_t'('0) : s_e;
    s_e = fe ? ins_t'('0) : s_d;
    if (fd) begin
      s_d = '0;
      if (pc < prog.size()) pc++;
    end else if (!st) begin
      if (pc < prog.size()) begin
        s_d = prog[pc];
        pc++;
      end else begin
        s_d = '0;
      end
    end
  endtask

  // Asynchronous reset in the middle of a cycle; registered state must clear at once.
  task automatic mid_reset();
    #1 rst = 1'b1;
    #1;
    check_val("rst_regwriteW",   32'(bus.regwriteW),   32'd0);
    check_val("rst_memtoregW",   32'(bus.memtoregW),   32'd0);
    check_val("rst_memwriteM",   32'(bus.memwriteM),   32'd0);
    check_val("rst_regdstE",     32'(bus.regdstE),     32'd0);
    check_val("rst_alusrcE",     32'(bus.alusrcE),     32'd0);
    check_val("rst_alucontrolE", 32'(bus.alucontrolE), 32'd0);
    check_val("rst_pcsrcM",      32'(bus.pcsrcM),      32'd0);
    check_val("rst_forwardAE",   32'(bus.forwardAE),   32'd0);
    check_val("rst_forwardBE",   32'(bus.forwardBE),   32'd0);
    check_val("rst_stallcnt",    32'(bus.stallcnt),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) prog.push_back('0);
  endtask

  initial begin
    int mark;
    int guard;
    rst = 1'b1;
    bus.opD = '0; bus.functD = '0; bus.rsD = '0; bus.rtD = '0;
    bus.rsE = '0; bus.rtE = '0;
    bus.writeregE = '0; bus.writeregM = '0; bus.writeregW = '0;
    bus.zeroM = 1'b1;

    // ALU-ALU dependence: add $1,$2,$3 ; sub $4,$1,$5
    prog.push_back(r_ins(6'h20, 1, 2, 3));
    prog.push_back(r_ins(6'h22, 4, 1, 5));
    nops(3);
    // load-use: lw $1,0($0) ; add $2,$1,$1
    prog.push_back(i_ins(6'h23, 1, 0, 1'b0));
    prog.push_back(r_ins(6'h20, 2, 1, 1));
    nops(3);
    // taken beq followed by three writers that must be killed
    prog.push_back(i_ins(6'h04, 0, 0, 1'b1));
    prog.push_back(r_ins(6'h20, 6, 2, 3));
    prog.push_back(i_ins(6'h2b, 7, 0, 1'b0));
    prog.push_back(i_ins(6'h08, 8, 0, 1'b0));
    nops(3);
    // jump kills the addi in IF; later addi $0 with a dependent reader
    prog.push_back(j_ins());
    prog.push_back(i_ins(6'h08, 0, 0, 1'b0));
    nops(1);
    prog.push_back(i_ins(6'h08, 0, 1, 1'b0));
    prog.push_back(r_ins(6'h20, 9, 0, 0));
    nops(3);
    // remaining functs, unknown funct/opcode, untaken beq, sw after lw
    prog.push_back(r_ins(6'h24, 3, 1, 2));
    prog.push_back(r_ins(6'h25, 3, 3, 2));
    prog.push_back(r_ins(6'h2a, 5, 3, 1));
    prog.push_back(r_ins(6'h3f, 6, 5, 5));
    prog.push_back('{6'h3f, 6'h20, 5'd6, 5'd6, 5'd6, 1'b0});
    prog.push_back(i_ins(6'h04, 1, 2, 1'b0));
    prog.push_back(i_ins(6'h23, 2, 3, 1'b0));
    prog.push_back(i_ins(6'h2b, 2, 0, 1'b0));
    nops(3);
    // taken beq with a jump in ID at resolution time
    prog.push_back(i_ins(6'h04, 0, 0, 1'b1));
    nops(1);
    prog.push_back(j_ins());
    prog.push_back(r_ins(6'h20, 1, 2, 2));
    nops(3);
    // random dependent code over $0..$3
    for (int i = 0; i < 60; i++) prog.push_back(rnd_ins());
    mark = prog.size();
    // after reset: load-use again
    prog.push_back(i_ins(6'h23, 3, 0, 1'b0));
    prog.push_back(r_ins(6'h25, 2, 3, 0));
    nops(6);

    @(posedge clk);
    #1;
    check_val("reset_regwriteW",   32'(bus.regwriteW),   32'd0);
    check_val("reset_memwriteM",   32'(bus.memwriteM),   32'd0);
    check_val("reset_alucontrolE", 32'(bus.alucontrolE), 32'd0);
    check_val("reset_pcsrcM",      32'(bus.pcsrcM),      32'd0);
    check_val("reset_stallcnt",    32'(bus.stallcnt),    32'd0);
    rst = 1'b0;
    model_reset();
    pc = 0;

    guard = 0;
    while (pc < mark && guard < 2000) begin
      step();
      guard++;
    end
    check_val("reached_reset_point", 32'(pc >= mark), 32'd1);
    step();
    mid_reset();

    guard = 0;
    while (pc < prog.size() && guard < 2000) begin
      step();
      guard++;
    end
    check_val("program_done", 32'(pc >= prog.size()), 32'd1);
    for (int i = 0; i < 4; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
